fifo_serial_tx: RTL and testbench

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

---
 rtl/fifo_serial_tx.sv | 125 ++++++++++++
 tb/tb_fifo_serial_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// Pulls 9-bit words from an upstream FIFO and sends each as a serial frame:
// start, 9 data bits LSB first, parity, stop, with CLKS_PER_BIT clocks per bit.
module fifo_serial_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tx_en,
   input  logic        fifo_empty,
   input  logic [8:0]  fifo_dout,
   output logic        fifo_rd,
   output logic        ser_out,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int DATA_W = 9;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WAIT   = 3'd1;
   localparam logic [2:0] START  = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] PARITY = 3'd4;
   localparam logic [2:0] STOP   = 3'd5;

   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
   localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

   function automatic logic frame_parity(input logic [DATA_W-1:0] word);
      return (^word) ^ PARITY_ODD;
   endfunction

   logic [2:0]        state, state_n;
   logic [7:0]        cnt, cnt_n;
   logic [3:0]        bit_idx, bit_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              par, par_n;
   logic              ser_n;
   logic              bit_end;

   assign fifo_rd    = (state == IDLE) && tx_en && !fifo_empty && reset;
   assign busy       = (state != IDLE);
   assign bit_end    = (cnt == LAST_CNT);
   assign frame_done = (state == STOP) && bit_end;

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 8'd1;
      bit_n   = bit_idx;
      shreg_n = shreg;
      par_n   = par;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (fifo_rd) state_n = WAIT;
         end
         WAIT: begin
            cnt_n   = '0;
            state_n = START;
            shreg_n = fifo_dout;
            par_n   = frame_parity(fifo_dout);
         end
         START: if (bit_end) begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = DATA;
         end
         DATA: if (bit_end) begin
            cnt_n = '0;
            if (bit_idx == LAST_BIT) begin
               bit_n   = '0;
               state_n = PARITY;
            end else begin
               bit_n = bit_idx + 4'd1;
            end
         end
         PARITY: if (bit_end) begin
            cnt_n   = '0;
            state_n = STOP;
         end
         STOP: if (bit_end) begin
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   // The line level is decoded from the next state so the registered output
   // changes on the same edge as the state it belongs to.
   always_comb begin
      case (state_n)
         START:   ser_n = 1'b0;
         DATA:    ser_n = shreg_n[bit_n];
         PARITY:  ser_n = par_n;
         default: ser_n = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         ser_out   <= 1'b1;
         frame_cnt <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_n;
         shreg     <= shreg_n;
         par       <= par_n;
         ser_out   <= ser_n;
         frame_cnt <= frame_cnt + {15'd0, frame_done};
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench for fifo_serial_tx: an even-parity and an odd-parity instance
// share one upstream FIFO model; expected line levels are queued per fetched word.
module tb_fifo_serial_tx;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        tx_en = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [8:0]  fifo_dout = 9'h000;
   logic        fifo_rd, ser_out, busy, frame_done;
   logic [15:0] frame_cnt;
   logic        rd_o, ser_o, busy_o, done_o;
   logic [15:0] cnt_o;

   fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut (
      .clock(clock), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .ser_out(ser_out), .busy(busy),
      .frame_done(frame_done), .frame_cnt(frame_cnt));

   fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
      .clock(clock), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .fifo_rd(rd_o), .ser_out(ser_o), .busy(busy_o),
      .frame_done(done_o), .frame_cnt(cnt_o));

   always #5 clock = ~clock;

   typedef struct packed {
      logic line;
      logic line_odd;
      logic done;
      logic bsy;
   } exp_t;

   exp_t        exp_q[$];
   logic [8:0]  src_q[$];
   int          rd_cycles[$];
   int          low_at_rd[$];
   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          rd_seen = 0;
   int          done_seen = 0;
   int          busy_low = 0;
   logic        reset_nx = 1'b0;
   logic        tx_en_nx = 1'b0;
   logic [15:0] exp_cnt = 16'h0000;

   function automatic exp_t mk(input logic l, input logic lo, input logic d, input logic b);
      exp_t e;
      e.line = l; e.line_odd = lo; e.done = d; e.bsy = b;
      return e;
   endfunction

   task automatic push_frame(input logic [8:0] w);
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
      repeat (4) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 9; i++)
         repeat (4) exp_q.push_back(mk(w[i], w[i], 1'b0, 1'b1));
      repeat (4) exp_q.push_back(mk(^w, ~^w, 1'b0, 1'b1));
      repeat (3) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1));
   endtask

   // One clock: apply inputs after the falling edge, sample, compare, serve reads.
   task automatic cyc();
      exp_t       e;
      logic       exp_rd;
      logic [8:0] w;
      @(negedge clock);
      reset      = reset_nx;
      tx_en      = tx_en_nx;
      fifo_empty = (src_q.size() == 0);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b1, 1'b1, 1'b0, 1'b0);
      exp_rd = !e.bsy && tx_en && !fifo_empty && reset;
      checks += 10;
      if (ser_out !== e.line) begin errors++; $display("FAIL ser_out cycle %0d: got %b expected %b", cycle, ser_out, e.line); end
      if (ser_o !== e.line_odd) begin errors++; $display("FAIL ser_out_odd cycle %0d: got %b expected %b", cycle, ser_o, e.line_odd); end
      if (frame_done !== e.done) begin errors++; $display("FAIL frame_done cycle %0d: got %b expected %b", cycle, frame_done, e.done); end
      if (done_o !== e.done) begin errors++; $display("FAIL frame_done_odd cycle %0d: got %b expected %b", cycle, done_o, e.done); end
      if (busy !== e.bsy) begin errors++; $display("FAIL busy cycle %0d: got %b expected %b", cycle, busy, e.bsy); end
      if (busy_o !== e.bsy) begin errors++; $display("FAIL busy_odd cycle %0d: got %b expected %b", cycle, busy_o, e.bsy); end
      if (fifo_rd !== exp_rd) begin errors++; $display("FAIL fifo_rd cycle %0d: got %b expected %b", cycle, fifo_rd, exp_rd); end
      if (rd_o !== exp_rd) begin errors++; $display("FAIL fifo_rd_odd cycle %0d: got %b expected %b", cycle, rd_o, exp_rd); end
      if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL frame_cnt cycle %0d: got %h expected %h", cycle, frame_cnt, exp_cnt); end
      if (cnt_o !== exp_cnt) begin errors++; $display("FAIL frame_cnt_odd cycle %0d: got %h expected %h", cycle, cnt_o, exp_cnt); end
      if (e.done) exp_cnt = exp_cnt + 16'd1;
      if (frame_done === 1'b1) done_seen++;
      if (busy === 1'b0) busy_low++;
      if (fifo_rd === 1'b1) begin
         rd_seen++;
         rd_cycles.push_back(cycle);
         low_at_rd.push_back(busy_low);
         w = (src_q.size() > 0) ? src_q.pop_front() : 9'h000;
         fifo_dout = w;
         push_frame(w);
      end
      cycle++;
   endtask

   task automatic wait_rd(input int bound);
      int start = rd_seen;
      for (int i = 0; i < bound && rd_seen == start; i++) cyc();
      checks++;
      if (rd_seen == start) begin
         errors++;
         $display("FAIL wait_rd: no fifo_rd within %0d cycles, required one", bound);
      end
   endtask

   task automatic test_reset();
      src_q.push_back(9'h1A5);
      tx_en_nx = 1'b1;
      reset_nx = 1'b0;
      repeat (4) cyc();
      checks++;
      if (rd_seen !== 0) begin errors++; $display("FAIL reset_no_rd: got %0d reads, required 0", rd_seen); end
      checks++;
      if (ser_out !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_state: ser_out=%b busy=%b, required 1 0", ser_out, busy);
      end
   endtask

   task automatic test_single_frame();
      int c0 = cycle;
      reset_nx = 1'b1;
      wait_rd(5);
      checks++;
      if (rd_cycles.size() == 0 || rd_cycles[0] !== c0) begin
         errors++; $display("FAIL first_rd_cycle: got %0d, required %0d", (rd_cycles.size() > 0) ? rd_cycles[0] : -1, c0);
      end
      repeat (52) cyc();
      checks++;
      if (rd_seen !== 1) begin errors++; $display("FAIL single_rd_count: got %0d, required 1", rd_seen); end
      checks++;
      if (done_seen !== 1) begin errors++; $display("FAIL single_done_count: got %0d, required 1", done_seen); end
      checks++;
      if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt: got %h, required 0001", frame_cnt); end
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL single_drain: %0d expected cycles left, required 0", exp_q.size()); end
   endtask

   task automatic test_parity();
      int r0 = rd_seen;
      int d0 = done_seen;
      src_q.push_back(9'h000);
      src_q.push_back(9'h1FF);
      repeat (110) cyc();
      checks++;
      if (rd_seen - r0 !== 2) begin errors++; $display("FAIL parity_rd_count: got %0d, required 2", rd_seen - r0); end
      checks++;
      if (done_seen - d0 !== 2) begin errors++; $display("FAIL parity_done_count: got %0d, required 2", done_seen - d0); end
   endtask

   task automatic test_back_to_back();
      int r0 = rd_seen;
      rd_cycles.delete();
      low_at_rd.delete();
      repeat (3) src_q.push_back(9'($urandom_range(0, 511)));
      for (int i = 0; i < 200 && rd_seen - r0 < 3; i++) cyc();
      checks++;
      if (rd_cycles.size() !== 3) begin
         errors++; $display("FAIL b2b_rd_count: got %0d, required 3", rd_cycles.size());
      end else begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (rd_cycles[k] - rd_cycles[k-1] !== 50) begin
               errors++; $display("FAIL b2b_period %0d: got %0d cycles, required 50", k, rd_cycles[k] - rd_cycles[k-1]);
            end
            checks++;
            if (low_at_rd[k] - low_at_rd[k-1] !== 1) begin
               errors++; $display("FAIL b2b_idle %0d: got %0d idle cycles, required 1", k, low_at_rd[k] - low_at_rd[k-1]);
            end
         end
      end
      repeat (52) cyc();
   endtask

   task automatic test_idle();
      int r0 = rd_seen;
      int d0;
      tx_en_nx = 1'b1;
      repeat (100) cyc();
      checks++;
      if (rd_seen !== r0) begin errors++; $display("FAIL empty_no_rd: got %0d reads, required 0", rd_seen - r0); end
      tx_en_nx = 1'b0;
      src_q.push_back(9'h0C3);
      repeat (100) cyc();
      checks++;
      if (rd_seen !== r0) begin errors++; $display("FAIL txen_low_no_rd: got %0d reads, required 0", rd_seen - r0); end
      tx_en_nx = 1'b1;
      wait_rd(5);
      d0 = done_seen;
      repeat (12) cyc();
      tx_en_nx = 1'b0;
      src_q.push_back(9'h13C);
      repeat (60) cyc();
      checks++;
      if (rd_seen - r0 !== 1) begin errors++; $display("FAIL txen_drop_rd: got %0d reads, required 1", rd_seen - r0); end
      checks++;
      if (done_seen - d0 !== 1) begin errors++; $display("FAIL txen_drop_done: got %0d frames, required 1", done_seen - d0); end
      checks++;
      if (src_q.size() !== 1) begin errors++; $display("FAIL txen_drop_left: got %0d words, required 1", src_q.size()); end
      src_q.delete();
      tx_en_nx = 1'b1;
      cyc();
   endtask

   task automatic test_reset_abort();
      int d0;
      src_q.push_back(9'h0AA);
      wait_rd(5);
      repeat (22) cyc();
      reset_nx = 1'b0;
      cyc();
      reset_nx = 1'b1;
      exp_q.delete();
      exp_cnt = 16'h0000;
      d0 = done_seen;
      cyc();
      checks++;
      if (busy !== 1'b0 || ser_out !== 1'b1 || frame_cnt !== 16'h0000) begin
         errors++; $display("FAIL abort_state: busy=%b ser_out=%b frame_cnt=%h, required 0 1 0000", busy, ser_out, frame_cnt);
      end
      repeat (60) cyc();
      checks++;
      if (done_seen !== d0) begin errors++; $display("FAIL abort_done: got %0d pulses, required 0", done_seen - d0); end
   endtask

   task automatic test_wrap();
      force dut.frame_cnt = 16'hFFFF;
      force dut_odd.frame_cnt = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      cyc();
      cyc();
      release dut.frame_cnt;
      release dut_odd.frame_cnt;
      cyc();
      src_q.push_back(9'h155);
      wait_rd(5);
      repeat (51) cyc();
      checks++;
      if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h, required 0000", frame_cnt); end
      checks++;
      if (cnt_o !== 16'h0000) begin errors++; $display("FAIL wrap_cnt_odd: got %h, required 0000", cnt_o); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_parity();
      test_back_to_back();
      test_idle();
      test_reset_abort();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
